// File: rtl/axil_reg_arbiter_if.sv
// AXI4-Lite master-side bundle shared by axil_reg_arbiter and its register-bank slave.
interface axil_reg_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_arbiter.sv
// Two-requester arbiter running one AXI4-Lite register transaction at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (requester 0).
module axil_reg_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              req_ready,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  axil_reg_arbiter_if.master      m_axi
);

  typedef enum logic [2:0] {IDLE, WRITE, BRESP, READ, RRESP, DONE} state_t;

  state_t                state;
  logic                  gnt;
  logic                  win;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  aw_ok;
  logic                  w_ok;

`ifdef ARB_ROUND_ROBIN_EN
  logic last;

  // On contention the requester not served last wins; reset leaves requester 1 as last.
  always_comb begin
    if (&req_valid) win = ~last;
    else            win = ~req_valid[0];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)        last <= 1'b1;
    else if (|req_ready) last <= req_ready[1];
  end
`else
  assign win = ~req_valid[0];
`endif

  assign sel_write = win ? req_write[1] : req_write[0];
  assign sel_addr  = win ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = win ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];

  // Gated by ARESETN so the accept pulse also vanishes while reset is held.
  assign req_ready = (ARESETN && state == IDLE && |req_valid) ? (win ? 2'b10 : 2'b01) : 2'b00;

  assign m_axi.awprot = 3'b000;
  assign m_axi.arprot = 3'b000;
  assign m_axi.wstrb  = '1;

  // A channel counts as finished once its valid is low or is handshaking this cycle.
  assign aw_ok = !m_axi.awvalid || m_axi.awready;
  assign w_ok  = !m_axi.wvalid  || m_axi.wready;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state         <= IDLE;
      gnt           <= 1'b0;
      rsp_valid     <= 2'b00;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      m_axi.awaddr  <= '0;
      m_axi.awvalid <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.wvalid  <= 1'b0;
      m_axi.bready  <= 1'b0;
      m_axi.araddr  <= '0;
      m_axi.arvalid <= 1'b0;
      m_axi.rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            gnt <= win;
            if (sel_write) begin
              m_axi.awaddr  <= sel_addr;
              m_axi.wdata   <= sel_wdata;
              m_axi.awvalid <= 1'b1;
              m_axi.wvalid  <= 1'b1;
              state         <= WRITE;
            end else begin
              m_axi.araddr  <= sel_addr;
              m_axi.arvalid <= 1'b1;
              state         <= READ;
            end
          end
        end
        WRITE: begin
          if (m_axi.awvalid && m_axi.awready) m_axi.awvalid <= 1'b0;
          if (m_axi.wvalid && m_axi.wready)   m_axi.wvalid  <= 1'b0;
          if (aw_ok && w_ok) begin
            m_axi.bready <= 1'b1;
            state        <= BRESP;
          end
        end
        BRESP: begin
          if (m_axi.bvalid) begin
            m_axi.bready <= 1'b0;
            rsp_resp     <= m_axi.bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= gnt ? 2'b10 : 2'b01;
            state        <= DONE;
          end
        end
        READ: begin
          if (m_axi.arready) begin
            m_axi.arvalid <= 1'b0;
            m_axi.rready  <= 1'b1;
            state         <= RRESP;
          end
        end
        RRESP: begin
          if (m_axi.rvalid) begin
            m_axi.rready <= 1'b0;
            rsp_resp     <= m_axi.rresp;
            rsp_rdata    <= m_axi.rdata;
            rsp_valid    <= gnt ? 2'b10 : 2'b01;
            state        <= DONE;
          end
        end
        DONE: begin
          rsp_valid <= 2'b00;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// Self-checking bench for axil_reg_arbiter: register-bank slave model plus directed and random traffic.
module tb_axil_reg_arbiter;
  localparam int AW = 4;
  localparam int DW = 32;

  logic          ACLK = 1'b0;
  logic          ARESETN;
  logic [1:0]    req_valid, req_write, req_ready, rsp_valid, rsp_resp;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata;

  int checks = 0;
  int failures = 0;

  axil_reg_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axil_reg_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_resp  (rsp_resp),
    .rsp_rdata (rsp_rdata),
    .m_axi     (bus)
  );

  always #5 ACLK = ~ACLK;

  // Register-bank slave: awready can be held off, everything else answers next cycle.
  logic [31:0]   sreg [4];
  int            aw_delay;
  bit            err_rd;
  int            aw_wait;
  bit            aw_done, w_done;
  logic [AW-1:0] aw_l, wa;
  logic [DW-1:0] w_l, wd;
  logic          aw_hs, w_hs;

  assign bus.awready = bus.awvalid && (aw_wait >= aw_delay);
  assign bus.wready  = bus.wvalid;
  assign bus.arready = bus.arvalid;
  assign aw_hs = bus.awvalid && bus.awready;
  assign w_hs  = bus.wvalid && bus.wready;
  assign wa = aw_hs ? bus.awaddr : aw_l;
  assign wd = w_hs ? bus.wdata : w_l;

  always @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_wait <= 0; aw_done <= 1'b0; w_done <= 1'b0; aw_l <= '0; w_l <= '0;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
    end else begin
      if (bus.awvalid && !bus.awready) aw_wait <= aw_wait + 1;
      else aw_wait <= 0;
      if (aw_hs) begin aw_done <= 1'b1; aw_l <= bus.awaddr; end
      if (w_hs)  begin w_done <= 1'b1; w_l <= bus.wdata; end
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if ((aw_done || aw_hs) && (w_done || w_hs)) begin
        sreg[wa[3:2]] <= wd;
        bus.bvalid <= 1'b1; bus.bresp <= 2'b00;
        aw_done <= 1'b0; w_done <= 1'b0;
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        bus.rvalid <= 1'b1;
        if (err_rd && bus.araddr == 4'h4) begin bus.rresp <= 2'b10; bus.rdata <= 32'hDEADBEEF; end
        else begin bus.rresp <= 2'b00; bus.rdata <= sreg[bus.araddr[3:2]]; end
      end
    end
  end

  // Free-running bus monitors; the stimulus block works on differences.
  int awv_cyc = 0, wv_cyc = 0, axi_act = 0, bready_aw = 0, rsp0_cnt = 0, gnt1_cnt = 0;
  logic [AW-1:0] last_awaddr = '0;
  logic [DW-1:0] last_wdata = '0;
  logic [3:0]    last_wstrb = '0;
  logic [5:0]    last_prot = '0;

  always @(posedge ACLK) begin
    if (bus.awvalid) awv_cyc <= awv_cyc + 1;
    if (bus.wvalid)  wv_cyc  <= wv_cyc + 1;
    if (bus.awvalid || bus.wvalid || bus.arvalid || bus.bready || bus.rready) axi_act <= axi_act + 1;
    if (bus.bready && bus.awvalid) bready_aw <= bready_aw + 1;
    if (rsp_valid[0]) rsp0_cnt <= rsp0_cnt + 1;
    if (req_ready[1]) gnt1_cnt <= gnt1_cnt + 1;
    if (aw_hs) last_awaddr <= bus.awaddr;
    if (w_hs) begin last_wdata <= bus.wdata; last_wstrb <= bus.wstrb; end
    if (aw_hs || bus.arvalid) last_prot <= {bus.awprot, bus.arprot};
  end

  // Reference: register contents and the last-granted requester, per the arbitration rules.
  logic [31:0] model [4];
  bit          model_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input int r, input bit wr, input logic [3:0] a, input logic [31:0] d);
    req_write[r] = wr;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
  endtask

  task automatic run_txn(input int r, input bit wr, input logic [3:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output logic [1:0] rs, output int lat);
    int n;
    set_cmd(r, wr, a, d);
    req_valid[r] = 1'b1;
    n = 0;
    #1;
    while (!req_ready[r] && n < 50) begin @(negedge ACLK); #1; n++; end
    chk("grant", {63'd0, req_ready[r]}, 64'd1);
    model_last = (r == 1);
    @(negedge ACLK);
    req_valid[r] = 1'b0;
    lat = 1;
    while (!rsp_valid[r] && lat < 50) begin @(negedge ACLK); lat++; end
    rd = rsp_rdata;
    rs = rsp_resp;
  endtask

  task automatic run_pair(input bit wr0, input bit wr1, input logic [3:0] a0, input logic [3:0] a1,
                          input logic [31:0] d0, input logic [31:0] d1);
    int first, who, n;
    bit wrr;
    logic [3:0] aa;
    logic [31:0] dd, exp_rd;
`ifdef ARB_ROUND_ROBIN_EN
    first = model_last ? 0 : 1;
`else
    first = 0;
`endif
    set_cmd(0, wr0, a0, d0);
    set_cmd(1, wr1, a1, d1);
    req_valid = 2'b11;
    for (int s = 0; s < 2; s++) begin
      who = (s == 0) ? first : 1 - first;
      n = 0;
      #1;
      while (!req_ready[who] && n < 50) begin @(negedge ACLK); #1; n++; end
      chk("pair_grant", {62'd0, req_ready}, (who == 0) ? 64'd1 : 64'd2);
      model_last = (who == 1);
      @(negedge ACLK);
      req_valid[who] = 1'b0;
      wrr = (who == 0) ? wr0 : wr1;
      aa  = (who == 0) ? a0 : a1;
      dd  = (who == 0) ? d0 : d1;
      exp_rd = wrr ? 32'd0 : model[aa[3:2]];
      if (wrr) model[aa[3:2]] = dd;
      n = 0;
      while (!rsp_valid[who] && n < 50) begin @(negedge ACLK); n++; end
      chk("pair_rdata", {32'd0, rsp_rdata}, {32'd0, exp_rd});
      chk("pair_resp", {62'd0, rsp_resp}, 64'd0);
    end
  endtask

  initial begin
    logic [31:0] rd, d;
    logic [1:0] rs;
    int lat, n, b0, b1, b2, r, idx;
    bit wr;

    ARESETN = 1'b0; req_valid = 2'b11; req_write = '0; req_addr = '0; req_wdata = '0;
    aw_delay = 0; err_rd = 1'b0; model_last = 1'b1;
    repeat (2) @(negedge ACLK);
    chk("rst_req_ready", {62'd0, req_ready}, 64'd0);
    chk("rst_rsp_valid", {62'd0, rsp_valid}, 64'd0);
    chk("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("rst_rsp_resp", {62'd0, rsp_resp}, 64'd0);
    chk("rst_axi_valids", {59'd0, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 64'd0);
    chk("rst_axi_addr", {56'd0, bus.awaddr, bus.araddr}, 64'd0);
    req_valid = 2'b00;
    @(negedge ACLK); ARESETN = 1'b1;
    @(negedge ACLK);

    // Both requesters hold valid for four grants, then requester 0 withdraws.
    set_cmd(0, 1'b1, 4'h0, 32'hA0A0A0A0);
    set_cmd(1, 1'b1, 4'h4, 32'hB1B1B1B1);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      n = 0; #1;
      while (req_ready == 2'b00 && n < 50) begin @(negedge ACLK); #1; n++; end
`ifdef ARB_ROUND_ROBIN_EN
      chk($sformatf("grant_order%0d", k), {62'd0, req_ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
`else
      chk($sformatf("grant_order%0d", k), {62'd0, req_ready}, 64'd1);
`endif
      @(negedge ACLK);
    end
    req_valid[0] = 1'b0;
    n = 0; #1;
    while (req_ready == 2'b00 && n < 50) begin @(negedge ACLK); #1; n++; end
    chk("grant_after_drop", {62'd0, req_ready}, 64'd2);
    @(negedge ACLK);
    req_valid = 2'b00;
    model_last = 1'b1;
    repeat (6) @(negedge ACLK);

    // Requester 0 writes then reads back every register.
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 1'b1, 4'(i * 4), 32'(i + 1), rd, rs, lat);
      model[i] = 32'(i + 1);
      chk("wr_lat", 64'(lat), 64'd3);
      chk("wr_resp", {62'd0, rs}, 64'd0);
      chk("wr_rdata", {32'd0, rd}, 64'd0);
      chk("wr_awaddr", {60'd0, last_awaddr}, 64'(i * 4));
      chk("wr_wdata", {32'd0, last_wdata}, 64'(i + 1));
      chk("wr_wstrb", {60'd0, last_wstrb}, 64'hF);
    end
    for (int i = 0; i < 4; i++) begin
      run_txn(0, 1'b0, 4'(i * 4), 32'd0, rd, rs, lat);
      chk("rd_lat", 64'(lat), 64'd3);
      chk("rd_resp", {62'd0, rs}, 64'd0);
      chk("rd_data", {32'd0, rd}, {32'd0, model[i]});
    end
    chk("prot", {58'd0, last_prot}, 64'd0);

    // awready held off three cycles, wready immediate.
    aw_delay = 3; b0 = awv_cyc; b1 = wv_cyc; b2 = bready_aw;
    run_txn(1, 1'b1, 4'hC, 32'h5A5A1234, rd, rs, lat);
    model[3] = 32'h5A5A1234;
    chk("slow_aw_cycles", 64'(awv_cyc - b0), 64'd4);
    chk("slow_w_cycles", 64'(wv_cyc - b1), 64'd1);
    chk("slow_bready_early", 64'(bready_aw - b2), 64'd0);
    chk("slow_lat", 64'(lat), 64'd6);
    aw_delay = 0;

    // SLVERR read on 0x4 by requester 1.
    err_rd = 1'b1; b0 = rsp0_cnt;
    run_txn(1, 1'b0, 4'h4, 32'd0, rd, rs, lat);
    chk("slverr_resp", {62'd0, rs}, 64'd2);
    chk("slverr_rdata", {32'd0, rd}, 64'hDEADBEEF);
    chk("slverr_no_rsp0", 64'(rsp0_cnt - b0), 64'd0);
    err_rd = 1'b0;

    // Reset while waiting in BRESP; the slave already took AW/W so the write lands.
    set_cmd(0, 1'b1, 4'h8, 32'hC0FFEE01);
    req_valid[0] = 1'b1;
    n = 0; #1;
    while (!req_ready[0] && n < 50) begin @(negedge ACLK); #1; n++; end
    @(negedge ACLK); req_valid[0] = 1'b0;
    @(negedge ACLK);
    chk("pre_rst_bready", {63'd0, bus.bready}, 64'd1);
    model[2] = 32'hC0FFEE01;
    b0 = rsp0_cnt;
    ARESETN = 1'b0;
    #1;
    chk("arst_valids", {59'd0, bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 64'd0);
    chk("arst_rsp", {60'd0, rsp_valid, rsp_resp}, 64'd0);
    chk("arst_rdata", {32'd0, rsp_rdata}, 64'd0);
    chk("arst_addr", {24'd0, bus.awaddr, bus.araddr, bus.wdata}, 64'd0);
    repeat (2) @(negedge ACLK);
    chk("arst_no_rsp", 64'(rsp0_cnt - b0), 64'd0);
    ARESETN = 1'b1; model_last = 1'b1;
    @(negedge ACLK);
    run_txn(0, 1'b0, 4'h0, 32'd0, rd, rs, lat);
    chk("post_rst_lat", 64'(lat), 64'd3);
    chk("post_rst_rdata", {32'd0, rd}, {32'd0, model[0]});

    // Single-cycle request from requester 1 during requester 0's transaction.
    b1 = gnt1_cnt;
    set_cmd(0, 1'b1, 4'h4, 32'h13572468);
    req_valid[0] = 1'b1;
    n = 0; #1;
    while (!req_ready[0] && n < 50) begin @(negedge ACLK); #1; n++; end
    model_last = 1'b0;
    @(negedge ACLK); req_valid[0] = 1'b0;
    set_cmd(1, 1'b0, 4'h0, 32'd0);
    req_valid[1] = 1'b1;
    #1;
    chk("pulse_no_ready", {62'd0, req_ready}, 64'd0);
    @(negedge ACLK); req_valid[1] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 50) begin @(negedge ACLK); n++; end
    model[1] = 32'h13572468;
    b0 = axi_act;
    repeat (4) @(negedge ACLK);
    chk("pulse_bus_idle", 64'(axi_act - b0), 64'd0);
    chk("pulse_no_grant1", 64'(gnt1_cnt - b1), 64'd0);

    // Random single and contended traffic against the register model.
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        run_pair(1'($urandom), 1'($urandom), 4'($urandom_range(0, 3) * 4), 4'($urandom_range(0, 3) * 4),
                 $urandom, $urandom);
      end else begin
        r = $urandom_range(0, 1); wr = 1'($urandom); idx = $urandom_range(0, 3); d = $urandom;
        run_txn(r, wr, 4'(idx * 4), d, rd, rs, lat);
        chk("rand_rdata", {32'd0, rd}, wr ? 64'd0 : {32'd0, model[idx]});
        chk("rand_resp", {62'd0, rs}, 64'd0);
        chk("rand_lat", 64'(lat), 64'd3);
        if (wr) model[idx] = d;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
